// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage sequencer.
// Holds the fetch word type, the action/redirect-source enums, the F2D bundle
// layout and the fetch_ctrl state encoding.
`ifndef SUPER
`define SUPER 2
`endif

package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int F2D_EPOCH_W = 2;

  typedef logic [XLEN-1:0] word;

  typedef enum logic [1:0] {
    Stall    = 2'd0,
    Dequeue  = 2'd1,
    Redirect = 2'd2
  } FetchAction;

  // Numeric order is the priority order: a larger value always wins.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    DEC    = 2'd1,
    EXEC   = 2'd2,
    COMMIT = 2'd3
  } RedirSrc;

  // Bundle held in the fetch-to-decode register.
  typedef struct packed {
    logic                   valid;
    logic [F2D_EPOCH_W-1:0] epoch;
    word                    pc;
    logic [`SUPER-1:0]      slot_valid;
  } F2D;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MISS = 2'd1,
    HOLD = 2'd2
  } fc_state_t;

endpackage

// File: rtl/fetch_ctrl_redir_pick.sv
// redir_pick: combinational priority select of the redirect that fetch must act on.
// Ports: three redirect sources (commit/exec/dec valid+pc), the pending redirect
// (valid/src/pc); outputs the effective redirect as valid/src/pc.
module redir_pick
  import fetch_pkg::*;
(
  input  logic    commit_valid,
  input  word     commit_pc,
  input  logic    exec_valid,
  input  word     exec_pc,
  input  logic    dec_valid,
  input  word     dec_pc,
  input  logic    pend_valid,
  input  RedirSrc pend_src,
  input  word     pend_pc,
  output logic    valid,
  output RedirSrc src,
  output word     pc
);

  RedirSrc in_src;
  word     in_pc;

  always_comb begin
    in_src = NONE;
    in_pc  = '0;
    if (commit_valid) begin
      in_src = COMMIT;
      in_pc  = commit_pc;
    end else if (exec_valid) begin
      in_src = EXEC;
      in_pc  = exec_pc;
    end else if (dec_valid) begin
      in_src = DEC;
      in_pc  = dec_pc;
    end

    // Pending only beats a strictly lower-priority arrival; on a tie the newer
    // request is the one that reflects the latest machine state.
    if (pend_valid && (pend_src > in_src)) begin
      src = pend_src;
      pc  = pend_pc;
    end else begin
      src = in_src;
      pc  = in_pc;
    end
    valid = (src != NONE);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: per-cycle fetch sequencer (Stall/Dequeue/Redirect), epoch and F2D kill.
// Ports: clk/rst, I$ ready/valid, decode ready, commit/exec/dec redirects in;
// action, redirect_pc, f2d_kill, epoch and miss/redirect performance counters out.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int SUPER   = `SUPER,
  parameter int EPOCH_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               icache_req_ready,
  input  logic [SUPER-1:0]   icache_valid,
  input  logic               dec_ready,
  input  logic               commit_redir_valid,
  input  word                commit_redir_pc,
  input  logic               exec_redir_valid,
  input  word                exec_redir_pc,
  input  logic               dec_redir_valid,
  input  word                dec_redir_pc,
  output FetchAction         action,
  output word                redirect_pc,
  output logic               f2d_kill,
  output logic [EPOCH_W-1:0] epoch,
  output logic [CNT_W-1:0]   miss_cycles,
  output logic [CNT_W-1:0]   redirect_count
);

  fc_state_t state;
  logic      pend_valid;
  RedirSrc   pend_src;
  word       pend_pc;
  logic      pend_live;

  logic      eff_valid;
  RedirSrc   eff_src;
  word       eff_pc;

  // Only slot 0 decides whether a bundle has arrived; the other slots are
  // consumed downstream.
  logic      unused_slots;
  assign unused_slots = ^icache_valid;

  // A pending redirect only exists in HOLD; gating by state keeps the two from
  // ever disagreeing.
  assign pend_live = pend_valid && (state == HOLD);

  redir_pick u_pick (
    .commit_valid (commit_redir_valid),
    .commit_pc    (commit_redir_pc),
    .exec_valid   (exec_redir_valid),
    .exec_pc      (exec_redir_pc),
    .dec_valid    (dec_redir_valid),
    .dec_pc       (dec_redir_pc),
    .pend_valid   (pend_live),
    .pend_src     (pend_src),
    .pend_pc      (pend_pc),
    .valid        (eff_valid),
    .src          (eff_src),
    .pc           (eff_pc)
  );

  always_comb begin
    action      = Stall;
    redirect_pc = '0;
    f2d_kill    = 1'b0;
    if (rst) begin
      f2d_kill = 1'b1;
    end else if (eff_valid) begin
      // The bundle in F2D is wrong-path as soon as any redirect is known,
      // even if the I$ cannot take the new address yet.
      f2d_kill = 1'b1;
      if (icache_req_ready) begin
        action      = Redirect;
        redirect_pc = eff_pc;
      end
    end else if (icache_valid[0] && dec_ready && icache_req_ready) begin
      action = Dequeue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pend_valid     <= 1'b0;
      pend_src       <= NONE;
      pend_pc        <= '0;
      epoch          <= '0;
      miss_cycles    <= '0;
      redirect_count <= '0;
    end else if (eff_valid) begin
      if (icache_req_ready) begin
        state      <= RUN;
        pend_valid <= 1'b0;
        pend_src   <= NONE;
        pend_pc    <= '0;
        epoch      <= epoch + 1'b1;
        if (redirect_count != '1) redirect_count <= redirect_count + 1'b1;
      end else begin
        state      <= HOLD;
        pend_valid <= 1'b1;
        pend_src   <= eff_src;
        pend_pc    <= eff_pc;
      end
    end else if (!icache_valid[0]) begin
      state <= MISS;
      if (miss_cycles != '1) miss_cycles <= miss_cycles + 1'b1;
    end else begin
      state <= RUN;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios plus randomized traffic against
// a priority/queue-level reference model. Counters run at 4 bits so that
// saturation is reached during the random phase.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             icache_req_ready = 1'b0;
  logic [1:0]       icache_valid = 2'b00;
  logic             dec_ready = 1'b0;
  logic             commit_redir_valid = 1'b0;
  word              commit_redir_pc = '0;
  logic             exec_redir_valid = 1'b0;
  word              exec_redir_pc = '0;
  logic             dec_redir_valid = 1'b0;
  word              dec_redir_pc = '0;
  FetchAction       action;
  word              redirect_pc;
  logic             f2d_kill;
  logic [1:0]       epoch;
  logic [3:0]       miss_cycles;
  logic [3:0]       redirect_count;

  int errors = 0;
  int checks = 0;

  fetch_ctrl #(.SUPER(2), .EPOCH_W(2), .CNT_W(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .icache_req_ready   (icache_req_ready),
    .icache_valid       (icache_valid),
    .dec_ready          (dec_ready),
    .commit_redir_valid (commit_redir_valid),
    .commit_redir_pc    (commit_redir_pc),
    .exec_redir_valid   (exec_redir_valid),
    .exec_redir_pc      (exec_redir_pc),
    .dec_redir_valid    (dec_redir_valid),
    .dec_redir_pc       (dec_redir_pc),
    .action             (action),
    .redirect_pc        (redirect_pc),
    .f2d_kill           (f2d_kill),
    .epoch              (epoch),
    .miss_cycles        (miss_cycles),
    .redirect_count     (redirect_count)
  );

  always #5 clk = ~clk;

  // Reference model: pending redirect kept as (priority number, pc); counters as ints.
  bit          m_pend_v = 0;
  int          m_pend_pri = 0;
  logic [31:0] m_pend_pc = '0;
  int          m_epoch = 0, m_miss = 0, m_rc = 0;
  bit          n_pend_v = 0;
  int          n_pend_pri = 0;
  logic [31:0] n_pend_pc = '0;
  int          n_epoch = 0, n_miss = 0, n_rc = 0;
  logic [1:0]  e_act;
  logic [31:0] e_pc;
  logic        e_kill;

  always @(posedge clk) begin
    m_pend_v   <= n_pend_v;
    m_pend_pri <= n_pend_pri;
    m_pend_pc  <= n_pend_pc;
    m_epoch    <= n_epoch;
    m_miss     <= n_miss;
    m_rc       <= n_rc;
  end

  task automatic model_eval();
    int          in_pri, w_pri;
    logic [31:0] in_pc, w_pc;
    n_pend_v = m_pend_v; n_pend_pri = m_pend_pri; n_pend_pc = m_pend_pc;
    n_epoch = m_epoch; n_miss = m_miss; n_rc = m_rc;
    e_act = 2'd0; e_pc = '0; e_kill = 1'b0;
    if (rst) begin
      e_kill = 1'b1;
      n_pend_v = 0; n_pend_pri = 0; n_pend_pc = '0;
      n_epoch = 0; n_miss = 0; n_rc = 0;
    end else begin
      in_pri = 0; in_pc = '0;
      if (dec_redir_valid)    begin in_pri = 1; in_pc = dec_redir_pc;    end
      if (exec_redir_valid)   begin in_pri = 2; in_pc = exec_redir_pc;   end
      if (commit_redir_valid) begin in_pri = 3; in_pc = commit_redir_pc; end
      w_pri = in_pri; w_pc = in_pc;
      if (m_pend_v && m_pend_pri > in_pri) begin w_pri = m_pend_pri; w_pc = m_pend_pc; end
      if (w_pri > 0) begin
        e_kill = 1'b1;
        if (icache_req_ready) begin
          e_act = 2'd2; e_pc = w_pc;
          n_pend_v = 0;
          n_epoch = (m_epoch + 1) % 4;
          n_rc = (m_rc >= 15) ? 15 : m_rc + 1;
        end else begin
          n_pend_v = 1; n_pend_pri = w_pri; n_pend_pc = w_pc;
        end
      end else if (!icache_valid[0]) begin
        n_miss = (m_miss >= 15) ? 15 : m_miss + 1;
      end else if (dec_ready && icache_req_ready) begin
        e_act = 2'd1;
      end
    end
  endtask

  // Applies one cycle of inputs at the falling edge, updates the model and
  // leaves the caller 1ns later to sample the outputs.
  task automatic drive(input bit r, input bit rr, input logic [1:0] iv, input bit dr,
                       input bit cv, input logic [31:0] cp, input bit ev, input logic [31:0] ep,
                       input bit dv, input logic [31:0] dp);
    @(negedge clk);
    rst = r; icache_req_ready = rr; icache_valid = iv; dec_ready = dr;
    commit_redir_valid = cv; commit_redir_pc = cp;
    exec_redir_valid = ev; exec_redir_pc = ep;
    dec_redir_valid = dv; dec_redir_pc = dp;
    model_eval();
    #1;
  endtask

  task automatic test_reset();
    logic [34:0] want;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 2'b11, 1, 1, 32'h40, 0, 0, 0, 0);
      want = {Stall, 32'h0, 1'b1};
      checks++;
      if ({action, redirect_pc, f2d_kill} !== want) begin
        errors++; $display("FAIL reset_outputs: got %h want %h", {action, redirect_pc, f2d_kill}, want);
      end
    end
    checks++;
    if ({epoch, miss_cycles, redirect_count} !== 10'h0) begin
      errors++; $display("FAIL reset_regs: got %h want 0", {epoch, miss_cycles, redirect_count});
    end
  endtask

  task automatic test_dequeue();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({action, redirect_pc, f2d_kill, epoch} !== {Dequeue, 32'h0, 1'b0, 2'd0}) begin
        errors++; $display("FAIL dequeue cyc%0d: got act=%0d pc=%h kill=%b ep=%0d want act=1 pc=0 kill=0 ep=0",
                           i, action, redirect_pc, f2d_kill, epoch);
      end
    end
  endtask

  task automatic test_exec_dec();
    drive(0, 1, 2'b11, 1, 0, 0, 1, 32'h100, 1, 32'h200);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Redirect, 32'h100, 1'b1}) begin
      errors++; $display("FAIL exec_over_dec: got act=%0d pc=%h kill=%b want act=2 pc=100 kill=1", action, redirect_pc, f2d_kill);
    end
    drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({epoch, miss_cycles, redirect_count} !== {2'd1, 4'd0, 4'd1}) begin
      errors++; $display("FAIL exec_dec_regs: got %h want %h", {epoch, miss_cycles, redirect_count}, {2'd1, 4'd0, 4'd1});
    end
  endtask

  task automatic test_hold();
    drive(0, 0, 2'b11, 1, 0, 0, 1, 32'h100, 0, 0);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Stall, 32'h0, 1'b1}) begin
      errors++; $display("FAIL hold_c1: got act=%0d pc=%h kill=%b want act=0 pc=0 kill=1", action, redirect_pc, f2d_kill);
    end
    drive(0, 0, 2'b11, 1, 1, 32'h300, 0, 0, 0, 0);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Stall, 32'h0, 1'b1}) begin
      errors++; $display("FAIL hold_c2: got act=%0d pc=%h kill=%b want act=0 pc=0 kill=1", action, redirect_pc, f2d_kill);
    end
    drive(0, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Stall, 32'h0, 1'b1}) begin
      errors++; $display("FAIL hold_c3: got act=%0d pc=%h kill=%b want act=0 pc=0 kill=1", action, redirect_pc, f2d_kill);
    end
    // Release with a lower-priority exec arriving: the pending commit must win.
    drive(0, 1, 2'b11, 1, 0, 0, 1, 32'h400, 0, 0);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Redirect, 32'h300, 1'b1}) begin
      errors++; $display("FAIL hold_release: got act=%0d pc=%h kill=%b want act=2 pc=300 kill=1", action, redirect_pc, f2d_kill);
    end
    drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({action, f2d_kill, epoch, redirect_count} !== {Dequeue, 1'b0, 2'd2, 4'd2}) begin
      errors++; $display("FAIL hold_after: got act=%0d kill=%b ep=%0d rc=%0d want act=1 kill=0 ep=2 rc=2",
                         action, f2d_kill, epoch, redirect_count);
    end
    // Equal priority: the newer exec replaces the pending exec.
    drive(0, 0, 2'b11, 1, 0, 0, 1, 32'h500, 0, 0);
    drive(0, 1, 2'b11, 1, 0, 0, 1, 32'h600, 0, 0);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Redirect, 32'h600, 1'b1}) begin
      errors++; $display("FAIL equal_pri_newer: got act=%0d pc=%h kill=%b want act=2 pc=600 kill=1", action, redirect_pc, f2d_kill);
    end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({action, redirect_pc, f2d_kill} !== {Stall, 32'h0, 1'b0}) begin
        errors++; $display("FAIL miss_stall cyc%0d: got act=%0d pc=%h kill=%b want act=0 pc=0 kill=0", i, action, redirect_pc, f2d_kill);
      end
    end
    drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({action, f2d_kill, epoch, miss_cycles, redirect_count} !== {Dequeue, 1'b0, 2'd3, 4'd3, 4'd3}) begin
      errors++; $display("FAIL miss_exit: got act=%0d kill=%b ep=%0d miss=%0d rc=%0d want act=1 kill=0 ep=3 miss=3 rc=3",
                         action, f2d_kill, epoch, miss_cycles, redirect_count);
    end
    drive(0, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({action, f2d_kill} !== {Stall, 1'b0}) begin
      errors++; $display("FAIL dec_not_ready: got act=%0d kill=%b want act=0 kill=0", action, f2d_kill);
    end
    drive(0, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2'b00, 1, 1, 32'h800, 0, 0, 0, 0);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Redirect, 32'h800, 1'b1}) begin
      errors++; $display("FAIL redirect_in_miss: got act=%0d pc=%h kill=%b want act=2 pc=800 kill=1", action, redirect_pc, f2d_kill);
    end
    drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({action, epoch, miss_cycles, redirect_count} !== {Dequeue, 2'd0, 4'd4, 4'd4}) begin
      errors++; $display("FAIL miss_abandon: got act=%0d ep=%0d miss=%0d rc=%0d want act=1 ep=0 miss=4 rc=4",
                         action, epoch, miss_cycles, redirect_count);
    end
  endtask

  task automatic test_epoch_wrap();
    logic [1:0] want_ep;
    drive(1, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 1, 32'h10 * (k + 1));
      else       drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
      want_ep = 2'(k);
      checks++;
      if (epoch !== want_ep) begin
        errors++; $display("FAIL epoch_seq step%0d: got %0d want %0d", k, epoch, want_ep);
      end
    end
  endtask

  task automatic test_reset_hold();
    drive(0, 0, 2'b11, 1, 0, 0, 1, 32'h700, 0, 0);
    drive(1, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({action, redirect_pc, f2d_kill} !== {Stall, 32'h0, 1'b1}) begin
      errors++; $display("FAIL reset_in_hold: got act=%0d pc=%h kill=%b want act=0 pc=0 kill=1", action, redirect_pc, f2d_kill);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({action, redirect_pc, f2d_kill, epoch} !== {Dequeue, 32'h0, 1'b0, 2'd0}) begin
        errors++; $display("FAIL pending_discarded cyc%0d: got act=%0d pc=%h kill=%b ep=%0d want act=1 pc=0 kill=0 ep=0",
                           i, action, redirect_pc, f2d_kill, epoch);
      end
    end
  endtask

  task automatic test_random();
    logic [34:0] want_c;
    logic [9:0]  want_r;
    drive(1, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            {1'($urandom), ($urandom_range(0, 3) != 0)},
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 7) == 0), $urandom);
      want_c = {e_act, e_pc, e_kill};
      want_r = {2'(m_epoch), 4'(m_miss), 4'(m_rc)};
      checks++;
      if ({action, redirect_pc, f2d_kill} !== want_c) begin
        errors++; $display("FAIL rand_outputs cyc%0d: got %h want %h", i, {action, redirect_pc, f2d_kill}, want_c);
      end
      checks++;
      if ({epoch, miss_cycles, redirect_count} !== want_r) begin
        errors++; $display("FAIL rand_regs cyc%0d: got %h want %h", i, {epoch, miss_cycles, redirect_count}, want_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dequeue();
    test_exec_dec();
    test_hold();
    test_miss();
    test_epoch_wrap();
    test_reset_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the superscalar fetch stage. It merges redirect requests from commit, execute and decode, tracks I$ misses, and applies decode/I$ backpressure. From these it produces the per-cycle `FetchAction` (Stall/Dequeue/Redirect) and `redirectPC` consumed by `fetch`. It also owns the fetch epoch and the kill signal that squash wrong-path bundles in the F2D register.

## Interface
Parameters:
- SUPER, default `SUPER (2): fetch width, instructions per bundle
- EPOCH_W, default 2: fetch epoch counter width
- CNT_W, default 32: performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- icache_req_ready  in  1  I$ can accept a new fetch address this cycle
- icache_valid  in  SUPER  per-slot data valid from I$
- dec_ready  in  1  decode accepts the current bundle
- commit_redir_valid / commit_redir_pc  in  1 / word  exception or replay redirect from ROB
- exec_redir_valid / exec_redir_pc  in  1 / word  branch mispredict redirect
- dec_redir_valid / dec_redir_pc  in  1 / word  decode-time target fix (BTB miss on direct jump)
- action  out  FetchAction  to `fetch`
- redirect_pc  out  word  to `fetch`; 0 when action != Redirect
- f2d_kill  out  1  squash the bundle currently in F2D
- epoch  out  EPOCH_W  current fetch epoch
- miss_cycles  out  CNT_W  cycles spent in MISS, saturating
- redirect_count  out  CNT_W  redirects issued, saturating

## Operation
- FSM states: RUN, MISS, HOLD.
- Source priority: commit > exec > dec. The incoming candidate is the highest-priority valid source this cycle.
- Pending register holds valid, src and pc.
- Effective redirect: the incoming candidate, unless pending is valid with strictly higher priority, in which case pending wins. Equal priority: the incoming (newer) request wins.
- If an effective redirect exists and icache_req_ready=1:
  - action=Redirect, redirect_pc=effective pc, f2d_kill=1.
  - Next cycle: epoch+1 (wraps mod 2^EPOCH_W), pending cleared, redirect_count+1, state RUN.
- If an effective redirect exists and icache_req_ready=0:
  - action=Stall, f2d_kill=1.
  - The effective redirect is written to pending; state HOLD.
- No effective redirect, state RUN or MISS:
  - If icache_valid[0]=0: action=Stall, state MISS, miss_cycles+1.
  - Else if dec_ready and icache_req_ready: action=Dequeue. Otherwise action=Stall.
  - In both of these cases state goes to RUN.
- HOLD persists only while pending is valid. Leaving HOLD always goes through a Redirect.
- f2d_kill=0 whenever action is not Redirect and no redirect is pending or incoming.
- Counters saturate at all-ones.

## Timing
- action, redirect_pc and f2d_kill are combinational from the current inputs plus registered state/pending, and are valid in the same cycle.
- Redirect latency: 0 cycles when icache_req_ready=1. Otherwise the redirect is issued in the first cycle icache_req_ready=1.
- A MISS clears in the cycle icache_valid[0] rises. Dequeue can issue in that same cycle.
- While rst=1: action=Stall, f2d_kill=1, redirect_pc=0.
- Reset values: state RUN, pending cleared, epoch=0, miss_cycles=0, redirect_count=0.
- Reset mid-HOLD: the pending redirect is discarded.
- Redirect during MISS: issued immediately if icache_req_ready=1. The miss is abandoned and the state goes to RUN.
- Simultaneous commit and exec redirects: commit wins and exec is dropped, with no later replay.
- Epoch wraps 3→0 at EPOCH_W=2.

## Structure
- Shared package (`fetch_pkg`):
  - `word` typedef.
  - `FetchAction` enum: Stall=2'd0, Dequeue=2'd1, Redirect=2'd2.
  - `RedirSrc` enum: NONE=0, DEC=1, EXEC=2, COMMIT=3. The numeric order encodes priority.
  - F2D struct and `SUPER macro.
  - fetch_ctrl state enum.
- Sub-module `redir_pick`: combinational priority select over three sources plus pending. Outputs valid, src and pc.
- Remaining logic lives in fetch_ctrl: FSM, pending register, epoch, counters.

## Test plan
- Reset, then icache_valid=all-1, dec_ready=1, icache_req_ready=1 → action=Dequeue every cycle, epoch=0, f2d_kill=0.
- exec_redir pc=0x100 and dec_redir pc=0x200 in the same cycle, req_ready=1 → Redirect to 0x100, f2d_kill=1, epoch 0→1 next cycle, redirect_count=1.
- req_ready=0, exec_redir 0x100 in cycle 1, commit_redir 0x300 in cycle 2, req_ready=1 in cycle 4:
  - Stall with f2d_kill=1 in cycles 1–3.
  - Redirect to 0x300 in cycle 4.
  - HOLD→RUN afterwards.
- Pending commit 0x300 and incoming exec 0x400 on release → Redirect to 0x300.
- icache_valid=0 for 3 cycles, then all-1 with dec_ready=1:
  - Stall for 3 cycles, miss_cycles=3.
  - Dequeue in the 4th cycle, state RUN.
- Four redirects → epoch sequence 1, 2, 3, 0.
- rst asserted while in HOLD → pending cleared, action=Stall, then no Redirect after rst deasserts.
